// File: rtl/abnormality_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : abnormality_alarm_controller
// Description : Downstream responder to the temperature abnormality detector.
//               Debounces the raw abnormality flag. A confirmed abnormality
//               raises a latched operator alarm. The alarm is held until the
//               operator acknowledges it and the condition has stayed clear
//               for CLEAR_CYCLES samples. Confirmed events are counted in a
//               saturating counter.
//
// Optional    : `define ALARM_TIMEOUT_EN adds an unacknowledged-alarm timer
//               and the alarmEscalate output.
//
// Ports       : clk                    - system clock, rising edge
//               reset                  - asynchronous, active-high reset
//               temperatureAbnormality - raw abnormality flag, sampled each clk
//               alarmAck               - operator acknowledge (pulse or level)
//               alarmActive            - alarm indicator, high in ALARM/HOLD
//               alarmPending           - high in ALARM only (awaiting ack)
//               eventCount             - confirmed events, saturating
//               alarmState             - state (0 NORMAL,1 ARMING,2 ALARM,3 HOLD)
//               alarmEscalate          - (ALARM_TIMEOUT_EN only) sticky flag,
//                                        set after TIMEOUT_CYCLES in ALARM
//
// Revision    : 1.0 - initial release
// ============================================================================
module abnormality_alarm_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CLEAR_CYCLES    = 4,
    parameter int CNT_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 temperatureAbnormality,
    input  logic                 alarmAck,
    output logic                 alarmActive,
    output logic                 alarmPending,
    output logic [CNT_WIDTH-1:0] eventCount,
    output logic [1:0]           alarmState
`ifdef ALARM_TIMEOUT_EN
    ,
    output logic                 alarmEscalate
`endif
);

    // ------------------------------------------------------------------
    // Counter widths: clog2 of the cycle count, never narrower than 1 bit.
    // ------------------------------------------------------------------
    localparam int c_DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_CCNT_W = (CLEAR_CYCLES > 1)    ? $clog2(CLEAR_CYCLES)    : 1;

    localparam logic [c_DCNT_W-1:0]  c_DCNT_LAST = c_DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DCNT_W-1:0]  c_DCNT_ONE  = c_DCNT_W'(1);
    localparam logic [c_CCNT_W-1:0]  c_CCNT_LAST = c_CCNT_W'(CLEAR_CYCLES - 1);
    localparam logic [c_CCNT_W-1:0]  c_CCNT_ONE  = c_CCNT_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_NORMAL = 2'd0,
        S_ARMING = 2'd1,
        S_ALARM  = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_DCNT_W-1:0]   r_debounceCnt;
    logic [c_CCNT_W-1:0]   r_clearCnt;
    logic [CNT_WIDTH-1:0]  r_eventCount;
    logic                  r_alarmActive;
    logic                  r_alarmPending;

    logic [CNT_WIDTH-1:0]  w_eventCountNext;

    // Saturating increment: holds at all-ones instead of wrapping.
    assign w_eventCountNext = (r_eventCount == c_CNT_MAX) ? r_eventCount
                                                          : (r_eventCount + c_CNT_ONE);

    // ------------------------------------------------------------------
    // Main FSM. alarmActive/alarmPending are registered alongside the
    // state so that they change on exactly the same edge as alarmState.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_NORMAL;
            r_debounceCnt  <= '0;
            r_clearCnt     <= '0;
            r_eventCount   <= '0;
            r_alarmActive  <= 1'b0;
            r_alarmPending <= 1'b0;
        end else begin
            case (r_state)
                S_NORMAL: begin
                    // Acknowledge has no meaning here and is ignored.
                    if (temperatureAbnormality) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_state        <= S_ALARM;
                            r_eventCount   <= w_eventCountNext;
                            r_alarmActive  <= 1'b1;
                            r_alarmPending <= 1'b1;
                        end else begin
                            r_state       <= S_ARMING;
                            r_debounceCnt <= c_DCNT_ONE;
                        end
                    end
                end

                S_ARMING: begin
                    if (!temperatureAbnormality) begin
                        // Glitch shorter than the debounce window.
                        r_state       <= S_NORMAL;
                        r_debounceCnt <= '0;
                    end else if (r_debounceCnt == c_DCNT_LAST) begin
                        // Confirmed. An ack on this same edge is ignored, so
                        // the alarm is always seen as pending at least once.
                        r_state        <= S_ALARM;
                        r_debounceCnt  <= '0;
                        r_eventCount   <= w_eventCountNext;
                        r_alarmActive  <= 1'b1;
                        r_alarmPending <= 1'b1;
                    end else begin
                        r_debounceCnt <= r_debounceCnt + c_DCNT_ONE;
                    end
                end

                S_ALARM: begin
                    // Latched: only the operator can move us on.
                    if (alarmAck) begin
                        r_state        <= S_HOLD;
                        r_clearCnt     <= '0;
                        r_alarmPending <= 1'b0;
                    end
                end

                S_HOLD: begin
                    // Re-assertion restarts the clear window but is not a
                    // new event.
                    if (temperatureAbnormality) begin
                        r_clearCnt <= '0;
                    end else if (r_clearCnt == c_CCNT_LAST) begin
                        r_state       <= S_NORMAL;
                        r_clearCnt    <= '0;
                        r_alarmActive <= 1'b0;
                    end else begin
                        r_clearCnt <= r_clearCnt + c_CCNT_ONE;
                    end
                end

                default: begin
                    r_state        <= S_NORMAL;
                    r_debounceCnt  <= '0;
                    r_clearCnt     <= '0;
                    r_alarmActive  <= 1'b0;
                    r_alarmPending <= 1'b0;
                end
            endcase
        end
    end

    assign alarmActive  = r_alarmActive;
    assign alarmPending = r_alarmPending;
    assign eventCount   = r_eventCount;
    assign alarmState   = r_state;

`ifdef ALARM_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Unacknowledged-alarm timer. The timer holds the number of edges
    // already spent in ALARM; the edge that would bring it to
    // TIMEOUT_CYCLES sets the sticky escalation flag instead. The flag is
    // only ever set inside ALARM, so clearing it on the ack transition is
    // sufficient.
    // ------------------------------------------------------------------
    localparam int c_TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    logic [c_TMR_W-1:0] r_timer;
    logic               r_alarmEscalate;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer         <= '0;
            r_alarmEscalate <= 1'b0;
        end else if (r_state == S_ALARM) begin
            if (alarmAck) begin
                r_timer         <= '0;
                r_alarmEscalate <= 1'b0;
            end else if (r_timer == c_TMR_LAST) begin
                r_alarmEscalate <= 1'b1;
            end else begin
                r_timer <= r_timer + c_TMR_ONE;
            end
        end else begin
            r_timer <= '0;
        end
    end

    assign alarmEscalate = r_alarmEscalate;
`endif

endmodule
`default_nettype wire

// File: tb/tb_abnormality_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_abnormality_alarm_controller
// Description : Directed self-checking bench. Two controllers share one
//               stimulus: dutA with the default 8-bit event counter and
//               dutB with a 2-bit counter to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_abnormality_alarm_controller;

    logic       clk;
    logic       reset;
    logic       abn;
    logic       ack;

    logic       aActive, aPending, bActive, bPending;
    logic [7:0] aCount;
    logic [1:0] bCount;
    logic [1:0] aState, bState;
`ifdef ALARM_TIMEOUT_EN
    logic       aEsc, bEsc;
`endif

    int total = 0;
    int bad   = 0;
    int expB[5];

    abnormality_alarm_controller #(
        .DEBOUNCE_CYCLES(4), .CLEAR_CYCLES(4), .CNT_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) dutA (
        .clk(clk), .reset(reset),
        .temperatureAbnormality(abn), .alarmAck(ack),
        .alarmActive(aActive), .alarmPending(aPending),
        .eventCount(aCount), .alarmState(aState)
`ifdef ALARM_TIMEOUT_EN
        , .alarmEscalate(aEsc)
`endif
    );

    abnormality_alarm_controller #(
        .DEBOUNCE_CYCLES(4), .CLEAR_CYCLES(4), .CNT_WIDTH(2), .TIMEOUT_CYCLES(16)
    ) dutB (
        .clk(clk), .reset(reset),
        .temperatureAbnormality(abn), .alarmAck(ack),
        .alarmActive(bActive), .alarmPending(bPending),
        .eventCount(bCount), .alarmState(bState)
`ifdef ALARM_TIMEOUT_EN
        , .alarmEscalate(bEsc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkStatus(input string tag, input logic [1:0] st,
                             input logic act, input logic pend);
        chk({tag, ".stateA"},   32'(aState),   32'(st));
        chk({tag, ".stateB"},   32'(bState),   32'(st));
        chk({tag, ".activeA"},  32'(aActive),  32'(act));
        chk({tag, ".activeB"},  32'(bActive),  32'(act));
        chk({tag, ".pendingA"}, 32'(aPending), 32'(pend));
        chk({tag, ".pendingB"}, 32'(bPending), 32'(pend));
    endtask

    initial begin
        expB[0] = 1; expB[1] = 2; expB[2] = 3; expB[3] = 3; expB[4] = 3;
        reset = 1'b1;
        abn   = 1'b0;
        ack   = 1'b0;
        step();
        step();

        // ---- reset state ----
        chkStatus("rst", 2'd0, 1'b0, 1'b0);
        chk("rst.countA", 32'(aCount), 32'd0);
        chk("rst.countB", 32'(bCount), 32'd0);
`ifdef ALARM_TIMEOUT_EN
        chk("rst.escA", 32'(aEsc), 32'd0);
`endif
        reset = 1'b0;
        step();

        // ---- glitch: 3 high edges then low ----
        abn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chkStatus("glitch.arm", 2'd1, 1'b0, 1'b0);
        end
        abn = 1'b0;
        step();
        chkStatus("glitch.drop", 2'd0, 1'b0, 1'b0);
        chk("glitch.countA", 32'(aCount), 32'd0);

        // ---- confirm: 4 high edges ----
        abn = 1'b1;
        step(); step(); step();
        chkStatus("confirm.3rd", 2'd1, 1'b0, 1'b0);
        step();
        chkStatus("confirm.4th", 2'd2, 1'b1, 1'b1);
        chk("confirm.countA", 32'(aCount), 32'd1);
        chk("confirm.countB", 32'(bCount), 32'd1);
        abn = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chkStatus("confirm.latched", 2'd2, 1'b1, 1'b1);

        // ---- ack and clear ----
        ack = 1'b1;
        step();
        ack = 1'b0;
        chkStatus("ack", 2'd3, 1'b1, 1'b0);
        step(); step(); step();
        chkStatus("hold.low3", 2'd3, 1'b1, 1'b0);
        abn = 1'b1;
        step();
        chkStatus("hold.reabn", 2'd3, 1'b1, 1'b0);
        abn = 1'b0;
        step(); step(); step();
        chkStatus("hold.low3b", 2'd3, 1'b1, 1'b0);
        step();
        chkStatus("clear", 2'd0, 1'b0, 1'b0);
        chk("clear.countA", 32'(aCount), 32'd1);

        // ---- asynchronous reset mid-alarm ----
        abn = 1'b1;
        step(); step(); step(); step();
        chkStatus("pre-reset", 2'd2, 1'b1, 1'b1);
        chk("pre-reset.countA", 32'(aCount), 32'd2);
        abn   = 1'b0;
        reset = 1'b1;
        #1;  // well before the next clock edge
        chkStatus("async-rst", 2'd0, 1'b0, 1'b0);
        chk("async-rst.countA", 32'(aCount), 32'd0);
        chk("async-rst.countB", 32'(bCount), 32'd0);
        step(); step(); step();
        reset = 1'b0;
        chkStatus("post-rst", 2'd0, 1'b0, 1'b0);

        // ---- saturation, with ack on the confirming edge ----
        for (int i = 0; i < 5; i++) begin
            abn = 1'b1;
            step(); step(); step();
            ack = 1'b1;
            step();
            chkStatus("sat.alarm", 2'd2, 1'b1, 1'b1);
            chk("sat.countA", 32'(aCount), 32'(i + 1));
            chk("sat.countB", 32'(bCount), 32'(expB[i]));
            abn = 1'b0;
            step();
            ack = 1'b0;
            chkStatus("sat.hold", 2'd3, 1'b1, 1'b0);
            step(); step(); step(); step();
            chkStatus("sat.clear", 2'd0, 1'b0, 1'b0);
        end

`ifdef ALARM_TIMEOUT_EN
        // ---- escalation after 16 unacknowledged cycles in ALARM ----
        abn = 1'b1;
        step(); step(); step(); step();
        abn = 1'b0;
        chkStatus("to.alarm", 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) step();
        chk("to.esc15A", 32'(aEsc), 32'd0);
        step();
        chk("to.esc16A", 32'(aEsc), 32'd1);
        chk("to.esc16B", 32'(bEsc), 32'd1);
        step();
        chk("to.sticky", 32'(aEsc), 32'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("to.ackEsc", 32'(aEsc), 32'd0);
        chkStatus("to.hold", 2'd3, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/abnormality_alarm_controller.md
Name: abnormality_alarm_controller

Overview:
- Downstream responder to the temperature abnormality detector.
- Consumes the raw combinational `temperatureAbnormality` flag and debounces it.
- Raises a latched operator alarm, holds it until acknowledged and the condition has cleared, and counts confirmed events.
- Sits between the detector and the factory panel/indicator logic.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive high samples required to confirm an abnormality (>=1)
- CLEAR_CYCLES, 4, consecutive low samples required after ack to return to normal (>=1)
- CNT_WIDTH, 8, width of the confirmed-event counter
- TIMEOUT_CYCLES, 16, unacknowledged-alarm cycles before escalation (used only with ALARM_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- temperatureAbnormality  input  1  raw abnormality flag from detector, sampled each clk
- alarmAck  input  1  operator acknowledge, single-cycle or level, sampled each clk
- alarmActive  output  1  alarm indicator, high in ALARM and HOLD
- alarmPending  output  1  high in ALARM only (alarm awaiting acknowledge)
- eventCount  output  CNT_WIDTH  number of confirmed abnormality events, saturating
- alarmState  output  2  current FSM state encoding
- alarmEscalate  output  1  present only with ALARM_TIMEOUT_EN; see Optional Feature

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - state=NORMAL; all counters=0
  - alarmActive=0, alarmPending=0, eventCount=0, alarmEscalate=0
- All outputs are registered or decoded from registered state. No combinational path from the inputs to the outputs.
- State encoding: NORMAL=2'd0, ARMING=2'd1, ALARM=2'd2, HOLD=2'd3.
- NORMAL:
  - abn=1 with DEBOUNCE_CYCLES==1 -> ALARM, eventCount+1.
  - abn=1 otherwise -> ARMING, dcnt<=1.
  - alarmAck ignored.
- ARMING:
  - abn=0 -> NORMAL, dcnt<=0.
  - abn=1 with dcnt==DEBOUNCE_CYCLES-1 -> ALARM, eventCount+1, dcnt<=0.
  - Otherwise dcnt+1.
  - alarmAck ignored.
- Alarm latency: with default parameters, abn high at 4 consecutive rising edges -> alarmActive=1 immediately after the 4th edge.
- ALARM:
  - Latched; abn falling does not leave ALARM.
  - alarmAck=1 -> HOLD, ccnt<=0.
- HOLD:
  - abn=1 -> ccnt<=0.
  - abn=0 with ccnt==CLEAR_CYCLES-1 -> NORMAL.
  - abn=0 otherwise -> ccnt+1.
  - alarmAck ignored.
  - A re-asserted abnormality in HOLD is not a new event (no increment).
- eventCount saturates at 2^CNT_WIDTH-1. No wrap.
- Simultaneous ack and ALARM entry on the same edge: ack ignored; ALARM is entered with alarmPending=1.
- Reset mid-operation returns everything to reset values immediately (asynchronous), including eventCount.
- dcnt and ccnt width: clog2 of the respective parameter, minimum 1 bit.

Optional Feature:
- Macro: ALARM_TIMEOUT_EN.
- Defined:
  - Timer counts cycles spent in ALARM; cleared on leaving ALARM.
  - When the timer reaches TIMEOUT_CYCLES, alarmEscalate is set.
  - alarmEscalate is sticky until the ALARM->HOLD transition or reset.
- Undefined:
  - No timer logic and no alarmEscalate port.
  - All other behaviour identical.

Test Plan:
1. Reset: reset=1 for 3 cycles mid-alarm, release -> alarmActive=0, alarmPending=0, eventCount=0, alarmState=0 at once, before any clk edge.
2. Glitch: abn high 3 edges then low -> state NORMAL/ARMING only, alarmActive never 1, eventCount=0.
3. Confirm: abn high 4 edges -> after 4th edge alarmActive=1, alarmPending=1, alarmState=2, eventCount=1. Drop abn for 10 cycles with no ack -> still ALARM.
4. Ack/clear:
   - Pulse alarmAck 1 cycle -> alarmPending=0, alarmActive=1, alarmState=3.
   - Then abn low 3 cycles, high 1 cycle, low 4 cycles -> NORMAL only after the 4th consecutive low edge.
   - eventCount stays 1.
5. Saturation: CNT_WIDTH=2, drive 5 full confirm/ack/clear cycles -> eventCount 1,2,3,3,3. Also ack asserted on the confirming edge -> still enters ALARM with alarmPending=1.
6. Timeout (ALARM_TIMEOUT_EN, TIMEOUT_CYCLES=16): hold ALARM unacked -> alarmEscalate=1 after 16 cycles in ALARM. Ack -> alarmEscalate=0 on the same transition. Build without macro -> compiles, no port.
